uart_time_sender: RTL and testbench
===================================

UART_TIME_SENDER -- requirements
Module: uart_time_sender

Interface
REQ-001 The block SHALL provide parameter BUSY_TIMEOUT, default 16, meaning the maximum number of clocks to wait for i_tx_busy to rise after a start pulse.
REQ-002 The block SHALL provide parameter EOL_EN, default 1, meaning 1 appends CR LF to the frame and 0 omits it.
REQ-003 The block SHALL provide port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide port i_send_req, input, 1 bit: request to transmit one time frame; sampled only in IDLE.
REQ-006 The block SHALL provide port i_hour, input, 5 bits: hour value, binary.
REQ-007 The block SHALL provide port i_min, input, 6 bits: minute value, binary.
REQ-008 The block SHALL provide port i_sec, input, 6 bits: second value, binary.
REQ-009 The block SHALL provide port i_tx_busy, input, 1 bit: busy flag from the UART transmitter.
REQ-010 The block SHALL provide port o_tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-011 The block SHALL provide port o_tx_start, output, 1 bit: single-cycle start pulse to the UART transmitter.
REQ-012 The block SHALL provide port o_busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL provide port o_send_done, output, 1 bit: one-cycle pulse when the frame completes.
REQ-014 The block SHALL provide port o_send_err, output, 1 bit: one-cycle pulse when the frame is aborted on timeout.

Function
REQ-015 The frame SHALL be ASCII "HHMMSS" rendered as H1 H0 ':' M1 M0 ':' S1 S0, followed by 0x0D 0x0A when EOL_EN=1: 10 bytes with EOL, otherwise 8.
REQ-016 Each digit SHALL be 0x30 + (value/10) for the tens position and 0x30 + (value%10) for the units position, with no clamping: hour 31 renders "31" and minute 63 renders "63".
REQ-017 The FSM SHALL have exactly the states IDLE, LOAD, SEND, WAIT_BUSY and WAIT_IDLE.
REQ-018 IDLE to LOAD: i_send_req=1 sampled at edge N; at edge N+1 hour/min/sec SHALL be captured into internal registers and byte index set to 0.
REQ-019 LOAD to SEND SHALL be unconditional on the next edge.
REQ-020 In SEND, while i_tx_busy=1 the block SHALL hold state with o_tx_start=0; when i_tx_busy=0 it SHALL assert o_tx_start for exactly one cycle, o_tx_data = byte[index], then go to WAIT_BUSY.
REQ-021 Minimum latency SHALL be i_send_req sampled at edge N to o_tx_start high in the cycle after edge N+2.
REQ-022 In WAIT_BUSY, i_tx_busy=1 SHALL transition to WAIT_IDLE and clear the timeout counter.
REQ-023 If i_tx_busy stays 0 for BUSY_TIMEOUT clocks in WAIT_BUSY, the block SHALL pulse o_send_err for one cycle and return to IDLE without sending remaining bytes.
REQ-024 In WAIT_IDLE, i_tx_busy=0 with index < last SHALL increment index and go to SEND.
REQ-025 In WAIT_IDLE, i_tx_busy=0 with index = last SHALL pulse o_send_done for one cycle and go to IDLE.
REQ-026 o_tx_data SHALL remain stable from the start pulse until the index changes.
REQ-027 Input changes after capture SHALL NOT affect the frame in flight (no tearing).
REQ-028 i_send_req outside IDLE SHALL be ignored and not queued; a request held high through completion SHALL start a new frame from IDLE.
REQ-029 o_send_done and o_send_err SHALL never assert in the same cycle.
REQ-030 The block SHALL never issue more than one o_tx_start per byte.

Reset
REQ-031 When reset is asserted, state SHALL go to IDLE, o_tx_data=0x00, o_tx_start=0, o_busy=0, o_send_done=0, o_send_err=0, and index and timeout counter SHALL be 0, asynchronously.
REQ-032 Reset mid-frame SHALL abandon the frame with no done/err pulse; the first request after release SHALL start at byte 0.

Verification
REQ-033 Time 12:34:56 with EOL_EN=1 and a transmitter model -> bytes 31 32 3A 33 34 3A 35 36 0D 0A in order, 10 start pulses, one o_send_done.
REQ-034 Time 00:00:00, EOL_EN=0 -> 30 30 3A 30 30 3A 30 30, 8 pulses, done; hour 31, min 63, sec 63 -> 33 31 3A 36 33 3A 36 33.
REQ-035 Inputs changed to 23:59:59 and i_send_req re-pulsed during byte 3 -> frame unchanged, second request ignored.
REQ-036 i_tx_busy tied 0 -> one start pulse, o_send_err 16 clocks later, back in IDLE, o_busy=0.
REQ-037 i_tx_busy held 1 on request -> no start pulse until busy falls; reset asserted during byte 5 -> all outputs 0 at once, next request sends byte 0x31 first for 12:34:56.

Source files
------------

// File: rtl/uart_time_sender.sv
// Renders a captured hh:mm:ss time as ASCII and feeds it byte by byte to a UART transmitter.
// Start pulse 3 clocks after a request; each byte waits for busy to rise and then fall; a missing busy rise aborts the frame.
module uart_time_sender #(
    parameter int BUSY_TIMEOUT = 16,
    parameter bit EOL_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_send_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_busy,
    output logic       o_send_done,
    output logic       o_send_err
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE} state_t;

    localparam int             TW       = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_MAX  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [3:0]     LAST_IDX = EOL_EN ? 4'd9 : 4'd7;

    state_t        state_q, state_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] tens(input logic [5:0] v);
        return 8'h30 + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] units(input logic [5:0] v);
        return 8'h30 + 8'(v % 6'd10);
    endfunction

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            4'd0: cur_byte = tens({1'b0, hour_q});
            4'd1: cur_byte = units({1'b0, hour_q});
            4'd2: cur_byte = 8'h3A;
            4'd3: cur_byte = tens(min_q);
            4'd4: cur_byte = units(min_q);
            4'd5: cur_byte = 8'h3A;
            4'd6: cur_byte = tens(sec_q);
            4'd7: cur_byte = units(sec_q);
            4'd8: cur_byte = 8'h0D;
            4'd9: cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_send_req) state_d = LOAD;
            LOAD:      state_d = SEND;
            SEND:      if (!i_tx_busy) state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (i_tx_busy)              state_d = WAIT_IDLE;
                else if (tmo_q == TMO_MAX)  state_d = IDLE;
            end
            WAIT_IDLE: begin
                if (!i_tx_busy) state_d = (idx_q == LAST_IDX) ? IDLE : SEND;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are registered, so every pulse lands one cycle after the decision.
    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            LOAD: begin
                hour_d = i_hour;
                min_d  = i_min;
                sec_d  = i_sec;
                idx_d  = 4'd0;
                tmo_d  = '0;
            end
            SEND: begin
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    tmo_d      = '0;
                end
            end
            WAIT_BUSY: begin
                if (i_tx_busy)             tmo_d = '0;
                else if (tmo_q == TMO_MAX) err_d = 1'b1;
                else                       tmo_d = tmo_q + 1'b1;
            end
            WAIT_IDLE: begin
                if (!i_tx_busy) begin
                    if (idx_q == LAST_IDX) done_d = 1'b1;
                    else                   idx_d  = idx_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_send_done = done_q;
    assign o_send_err  = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_time_sender.sv
// Two instances (EOL on: index 1, EOL off: index 0) driven by a randomized transmitter model.
module tb_uart_time_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] req;
    logic [1:0] tx_busy;
    logic [1:0] tx_start;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] err;
    logic [7:0] tx_data [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] rx [2][32];
    int   rx_n    [2];
    int   done_n  [2];
    int   err_n   [2];
    int   rise    [2];
    int   hold    [2];
    time  first_t [2];
    time  start_t [2];
    time  err_t   [2];
    logic [1:0] force_en;
    logic [1:0] force_val;
    time  t0;

    always #5 clk = ~clk;

    uart_time_sender #(.BUSY_TIMEOUT(16), .EOL_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .i_send_req(req[0]), .i_hour(hour), .i_min(minute), .i_sec(second),
        .i_tx_busy(tx_busy[0]), .o_tx_data(tx_data[0]), .o_tx_start(tx_start[0]), .o_busy(busy[0]),
        .o_send_done(done[0]), .o_send_err(err[0])
    );

    uart_time_sender #(.BUSY_TIMEOUT(16), .EOL_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .i_send_req(req[1]), .i_hour(hour), .i_min(minute), .i_sec(second),
        .i_tx_busy(tx_busy[1]), .o_tx_data(tx_data[1]), .o_tx_start(tx_start[1]), .o_busy(busy[1]),
        .o_send_done(done[1]), .o_send_err(err[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Transmitter model and output monitor.
    initial begin
        tx_busy = 2'b00;
        for (int k = 0; k < 2; k++) begin
            rx_n[k] = 0; done_n[k] = 0; err_n[k] = 0; rise[k] = 0; hold[k] = 0;
            first_t[k] = 0; start_t[k] = 0; err_t[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (tx_start[k]) begin
                    if (rx_n[k] < 32) rx[k][rx_n[k]] = tx_data[k];
                    if (rx_n[k] == 0) first_t[k] = $time;
                    rx_n[k]++;
                    start_t[k] = $time;
                    rise[k] = $urandom_range(1, 4);
                    hold[k] = $urandom_range(1, 6);
                end
                if (done[k]) done_n[k]++;
                if (err[k]) begin
                    err_n[k]++;
                    err_t[k] = $time;
                end
                chk("done_err_overlap", int'(done[k] & err[k]), 0);
                if (force_en[k]) begin
                    tx_busy[k] = force_val[k];
                    rise[k] = 0;
                    hold[k] = 0;
                end else if (rise[k] > 0) begin
                    rise[k]--;
                    if (rise[k] == 0) tx_busy[k] = 1'b1;
                end else if (hold[k] > 0) begin
                    hold[k]--;
                    if (hold[k] == 0) tx_busy[k] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int k, input int h, input int m, input int s);
        hour = 5'(h); minute = 6'(m); second = 6'(s);
        rx_n[k] = 0;
        req[k] = 1'b1;
        t0 = $time;
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((tx_busy[k] || busy[k]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 200), 1);
        @(negedge clk);
    endtask

    task automatic wait_frame(input int k, input int ev0);
        int n = 0;
        while ((done_n[k] + err_n[k]) == ev0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_end_timeout", int'(n < 2000), 1);
        @(negedge clk);
    endtask

    task automatic wait_bytes(input int k, input int cnt);
        int n = 0;
        while (rx_n[k] < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("byte_wait_timeout", int'(n < 2000), 1);
    endtask

    task automatic check_frame(input int k, input int h, input int m, input int s, input string tag);
        logic [7:0] e [10];
        int n;
        e[0] = 8'(48 + h / 10); e[1] = 8'(48 + h % 10); e[2] = 8'h3A;
        e[3] = 8'(48 + m / 10); e[4] = 8'(48 + m % 10); e[5] = 8'h3A;
        e[6] = 8'(48 + s / 10); e[7] = 8'(48 + s % 10);
        e[8] = 8'h0D; e[9] = 8'h0A;
        n = (k == 1) ? 10 : 8;
        chk({tag, "_len"}, rx_n[k], n);
        for (int i = 0; i < n && i < rx_n[k]; i++) chk({tag, "_byte"}, int'(rx[k][i]), int'(e[i]));
    endtask

    task automatic normal_frame(input int k, input int h, input int m, input int s, input string tag);
        int d0, e0;
        wait_idle(k);
        d0 = done_n[k]; e0 = err_n[k];
        send(k, h, m, s);
        wait_frame(k, d0 + e0);
        check_frame(k, h, m, s, tag);
        chk({tag, "_latency"}, int'(first_t[k] - t0), 30);
        chk({tag, "_done"}, done_n[k] - d0, 1);
        chk({tag, "_err"}, err_n[k] - e0, 0);
    endtask

    initial begin
        int d0, e0;
        reset = 1'b1;
        req = 2'b00; hour = '0; minute = '0; second = '0;
        force_en = 2'b00; force_val = 2'b00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx_data", int'(tx_data[k]), 0);
            chk("rst_tx_start", int'(tx_start[k]), 0);
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_done", int'(done[k]), 0);
            chk("rst_err", int'(err[k]), 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        normal_frame(1, 12, 34, 56, "t123456");
        for (int i = 0; i < 4; i++)
            normal_frame(1, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), "rand_eol");
        normal_frame(0, 0, 0, 0, "t000000");
        normal_frame(0, 31, 63, 63, "t316363");
        for (int i = 0; i < 3; i++)
            normal_frame(0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), "rand_noeol");

        // Inputs and request change mid-frame.
        wait_idle(1);
        d0 = done_n[1]; e0 = err_n[1];
        send(1, 12, 34, 56);
        wait_bytes(1, 4);
        hour = 5'd23; minute = 6'd59; second = 6'd59;
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_frame(1, d0 + e0);
        repeat (30) @(negedge clk);
        check_frame(1, 12, 34, 56, "notear");
        chk("notear_done", done_n[1] - d0, 1);
        chk("notear_idle", int'(busy[1]), 0);

        // Transmitter never goes busy.
        wait_idle(1);
        force_val[1] = 1'b0; force_en[1] = 1'b1;
        d0 = done_n[1]; e0 = err_n[1];
        send(1, 12, 34, 56);
        wait_frame(1, d0 + e0);
        chk("tmo_starts", rx_n[1], 1);
        chk("tmo_byte0", int'(rx[1][0]), 8'h31);
        chk("tmo_err", err_n[1] - e0, 1);
        chk("tmo_done", done_n[1] - d0, 0);
        chk("tmo_delay", int'(err_t[1] - start_t[1]), 160);
        chk("tmo_idle", int'(busy[1]), 0);
        force_en[1] = 1'b0;

        // Transmitter busy at request, then reset during byte 5.
        force_val[1] = 1'b1; force_en[1] = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_n[1]; e0 = err_n[1];
        send(1, 12, 34, 56);
        repeat (20) @(negedge clk);
        chk("held_no_start", rx_n[1], 0);
        chk("held_busy", int'(busy[1]), 1);
        force_val[1] = 1'b0;
        @(negedge clk);
        force_en[1] = 1'b0;
        wait_bytes(1, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_tx_data", int'(tx_data[1]), 0);
        chk("async_tx_start", int'(tx_start[1]), 0);
        chk("async_busy", int'(busy[1]), 0);
        chk("async_done", int'(done[1]), 0);
        chk("async_err", int'(err[1]), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_abandon_done", done_n[1] - d0, 0);
        chk("rst_abandon_err", err_n[1] - e0, 0);
        normal_frame(1, 12, 34, 56, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
